cbit_ram_ctrl: RTL

Controller for the access-bit ("cbit") dual-port BRAM that backs the memcached key store. Port 2 (data + bit-set-on-read) is shared round-robin between the P4 pipeline requester (A) and the control-plane requester (B). Port 1 (bit read-and-clear) is driven by a CLOCK-style victim sweeper that returns the first slot not read since its last sweep. The block sits between the requesters and one RAM instance. It drives every RAM port pin, and the RAM carries no control logic of its own.

---
 rtl/cbit_ram_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cbit_ram_ctrl.sv
// Access-bit RAM controller: round-robin arbiter for the data/bit-set port and a
// CLOCK-style victim sweeper on the bit read-and-clear port.
module cbit_ram_ctrl #(
    parameter int L2_DEPTH = 8,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                a_req_valid,
    output logic                a_req_ready,
    input  logic                a_req_we,
    input  logic [L2_DEPTH-1:0] a_req_addr,
    input  logic [WIDTH-1:0]    a_req_data,
    output logic                a_rsp_valid,
    output logic [WIDTH-1:0]    a_rsp_data,
    input  logic                b_req_valid,
    output logic                b_req_ready,
    input  logic                b_req_we,
    input  logic [L2_DEPTH-1:0] b_req_addr,
    input  logic [WIDTH-1:0]    b_req_data,
    output logic                b_rsp_valid,
    output logic [WIDTH-1:0]    b_rsp_data,
    input  logic                vic_req_valid,
    output logic                vic_req_ready,
    output logic                vic_rsp_valid,
    output logic                vic_rsp_found,
    output logic [L2_DEPTH-1:0] vic_rsp_addr,
    output logic                ram_en1,
    output logic                ram_we1,
    output logic [L2_DEPTH-1:0] ram_addr1,
    output logic [0:0]          ram_din1,
    output logic                ram_rst1,
    output logic                ram_regce1,
    input  logic                ram_dout1,
    output logic                ram_en2,
    output logic                ram_we2,
    output logic [L2_DEPTH-1:0] ram_addr2,
    output logic [WIDTH-1:0]    ram_din2,
    output logic                ram_rst2,
    output logic                ram_regce2,
    input  logic [WIDTH-1:0]    ram_dout2
);

    localparam logic [L2_DEPTH:0] DEPTH_W = (L2_DEPTH+1)'(2**L2_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} vic_state_e;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    owner_e     last_q, last_d;
    tag_t       tag1_q, tag1_d, tag2_q;
    vic_state_e state_q, state_d;
    logic [L2_DEPTH-1:0] hand_q, hand_d, vic_addr_q, vic_addr_d;
    logic [L2_DEPTH:0]   count_q, count_d, count_inc;
    logic                vic_found_q, vic_found_d;
    logic                a_grant, b_grant, p2_grant, collide;

    assign ram_we1    = 1'b0;
    assign ram_din1   = 1'b0;
    assign ram_regce1 = 1'b1;
    assign ram_regce2 = 1'b1;
    assign ram_rst1   = ~resetn;
    assign ram_rst2   = ~resetn;

    // Gated with resetn so no handshake can complete while the block is held in reset.
    assign a_grant  = resetn & a_req_valid & (~b_req_valid | (last_q == OWN_B));
    assign b_grant  = resetn & b_req_valid & (~a_req_valid | (last_q == OWN_A));
    assign p2_grant = a_grant | b_grant;

    assign a_req_ready = a_grant;
    assign b_req_ready = b_grant;
    assign ram_en2     = p2_grant;
    assign ram_we2     = a_grant ? a_req_we   : (b_grant & b_req_we);
    assign ram_addr2   = b_grant ? b_req_addr : a_req_addr;
    assign ram_din2    = b_grant ? b_req_data : a_req_data;

    assign a_rsp_valid = tag2_q.valid & (tag2_q.owner == OWN_A);
    assign b_rsp_valid = tag2_q.valid & (tag2_q.owner == OWN_B);
    assign a_rsp_data  = a_rsp_valid ? ram_dout2 : '0;
    assign b_rsp_data  = b_rsp_valid ? ram_dout2 : '0;

    assign ram_addr1     = hand_q;
    assign vic_req_ready = resetn & (state_q == S_IDLE);
    assign vic_rsp_valid = (state_q == S_DONE);
    assign vic_rsp_found = vic_found_q;
    assign vic_rsp_addr  = vic_addr_q;

    // Port 2 always wins a same-slot race so a fresh access is never cleared by the sweep.
    assign collide   = p2_grant & (ram_addr2 == hand_q);
    assign count_inc = count_q + 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        last_d      = last_q;
        tag1_d      = '{valid: p2_grant, owner: (b_grant ? OWN_B : OWN_A)};
        state_d     = state_q;
        hand_d      = hand_q;
        count_d     = count_q;
        vic_found_d = vic_found_q;
        vic_addr_d  = vic_addr_q;
        ram_en1     = 1'b0;

        if (a_grant)      last_d = OWN_A;
        else if (b_grant) last_d = OWN_B;

        unique case (state_q)
            S_IDLE: begin
                if (vic_req_valid) begin
                    count_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!collide) begin
                    ram_en1 = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_CHECK;
            S_CHECK: begin
                hand_d = hand_q + 1'b1;
                if (!ram_dout1) begin
                    vic_found_d = 1'b1;
                    vic_addr_d  = hand_q;
                    state_d     = S_DONE;
                end else begin
                    count_d = count_inc;
                    if (count_inc == DEPTH_W) begin
                        vic_found_d = 1'b0;
                        vic_addr_d  = hand_q + 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q      <= OWN_B;
            tag1_q      <= '0;
            tag2_q      <= '0;
            state_q     <= S_IDLE;
            hand_q      <= '0;
            count_q     <= '0;
            vic_found_q <= 1'b0;
            vic_addr_q  <= '0;
        end else begin
            last_q      <= last_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            state_q     <= state_d;
            hand_q      <= hand_d;
            count_q     <= count_d;
            vic_found_q <= vic_found_d;
            vic_addr_q  <= vic_addr_d;
        end
    end

endmodule
